enc_bin2onehot_pipe: RTL and testbench
======================================

Name: enc_bin2onehot_pipe

Overview:
Parametrised, pipelined successor to the combinational binary-to-onehot encoder. It decodes an IN_W-bit binary code into an OUT_W-bit one-hot word, with valid/ready handshakes on both sides and a 2-entry skid buffer so that back-pressure never drops a code. Codes that fall outside the output range are flagged rather than silently aliased. It sits between the command decoders and the per-lane enable logic.

Parameters:
IN_W, 4, width of the binary input code (1..8)
OUT_W, 16, width of the one-hot output; must be <= 2**IN_W; codes >= OUT_W are out-of-range
CNT_W, 8, width of the error counter (used only with ENC_BIN2ONEHOT_ERRCNT_EN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  input code valid
in_ready  output  1  block can accept a code this cycle
in  input  IN_W  binary code
out_valid  output  1  output entry valid
out_ready  input  1  downstream accepts the output entry
out  output  OUT_W  one-hot word; all-zero for an out-of-range code
out_err  output  1  current output entry came from an out-of-range code
err_sticky  output  1  set by any accepted out-of-range code; held until cleared
err_clr  input  1  synchronous clear of err_sticky (and of err_cnt when present)
err_cnt  output  CNT_W  saturating count of accepted out-of-range codes (only with macro)

Behaviour:
- Reset (rst=0, asynchronous): buffer EMPTY; in_ready=0 while rst=0, then 1 from the first clock edge after release; out_valid=0; out=0; out_err=0; err_sticky=0; err_cnt=0.
- Accept on in_valid && in_ready; emit on out_valid && out_ready.
- Decode: in < OUT_W gives out = 1 << in and out_err=0. in >= OUT_W gives out = 0 and out_err=1. Decode happens at write time; each entry stores {out, out_err}.
- Buffer FSM states: EMPTY, ONE, TWO. Entries are always emitted in acceptance order.
  - EMPTY: on accept -> ONE. Out_valid rises in the next cycle, so latency is 1 cycle.
  - ONE: accept without emit -> TWO. Emit without accept -> EMPTY. Accept and emit together -> ONE, with the new entry replacing the head.
  - TWO: emit -> ONE. No accept is possible in this state.
- in_ready = (state != TWO) and not in reset. It is registered and does not combinationally depend on out_ready.
- With out_valid=1 and out_ready=0, out and out_err hold stable until the entry is accepted.
- out_valid=1 implies exactly one bit of out is set, or out=0 with out_err=1.
- err_sticky: set in the cycle after an out-of-range code is accepted; cleared by err_clr. If a set and err_clr occur in the same cycle, set wins.
- Full throughput of 1 code/cycle when out_ready is held at 1.
- A reset asserted mid-operation flushes both entries immediately (asynchronously); no partial output is emitted.
- OUT_W == 2**IN_W: no code is out-of-range, so out_err and err_sticky stay 0.

Optional Feature:
ENC_BIN2ONEHOT_ERRCNT_EN
- Defined: the err_cnt port exists. It increments by 1 per accepted out-of-range code and saturates at 2**CNT_W-1. err_clr zeroes it; if an increment and err_clr occur in the same cycle, the result is 1.
- Not defined: the err_cnt port and its counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release -> out_valid=0, out=0, err_sticky=0, in_ready=1 one edge after release.
- Streaming: IN_W=4, OUT_W=16, out_ready=1, in=0,5,15 on consecutive cycles -> out=0x0001,0x0020,0x8000 on the next three cycles, out_err=0 throughout.
- Back-pressure: out_ready=0, send codes 3 then 9 -> in_ready=0 after the second accept, out holds 0x0008. Raise out_ready -> 0x0008 then 0x0200, in_ready=1 again, no code lost.
- Out-of-range: OUT_W=12, send in=13 -> out=0, out_err=1, err_sticky=1. Pulse err_clr -> err_sticky=0. err_clr in the same cycle as a new error -> err_sticky stays 1.
- Mid-op reset: two entries buffered, assert rst=0 asynchronously -> out_valid=0 at once, and after release the first output comes only from a new input.
- Macro on, CNT_W=2: 5 out-of-range codes -> err_cnt=3 (saturated). err_clr -> 0. err_clr plus an error together -> 1.

Source files
------------

// File: rtl/enc_bin2onehot_pipe.sv
// -----------------------------------------------------------------------------
// enc_bin2onehot_pipe
//
// Pipelined binary-to-onehot encoder with valid/ready handshakes on both sides.
// A 2-entry skid buffer sits behind the decoder, so a stalled consumer never
// causes a code to be dropped. A code that has no output lane (code >= OUT_W)
// does not wrap onto a lane. It is stored as an all-zero word with out_err set,
// and it also raises the sticky error flag.
//
// Optional feature macro: ENC_BIN2ONEHOT_ERRCNT_EN
//   Defined     : adds parameter CNT_W and output err_cnt. err_cnt is a
//                 saturating count of accepted out-of-range codes.
//   Not defined : err_cnt and its counter logic do not exist.
//
// Parameters:
//   IN_W   width of the binary input code (1..8)
//   OUT_W  width of the one-hot output (<= 2**IN_W)
//   CNT_W  width of the error counter (only with ENC_BIN2ONEHOT_ERRCNT_EN)
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous reset, active low
//   in_valid    input code valid
//   in_ready    block can accept a code this cycle (registered)
//   in          binary code
//   out_valid   output entry valid
//   out_ready   downstream accepts the output entry
//   out         one-hot word; zero for an out-of-range code
//   out_err     current output entry came from an out-of-range code
//   err_sticky  set by any accepted out-of-range code; held until cleared
//   err_clr     synchronous clear of err_sticky (and err_cnt when present)
//   err_cnt     saturating error count (only with ENC_BIN2ONEHOT_ERRCNT_EN)
// -----------------------------------------------------------------------------
module enc_bin2onehot_pipe #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
`ifdef ENC_BIN2ONEHOT_ERRCNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             out_err,
  output logic             err_sticky,
  input  logic             err_clr
`ifdef ENC_BIN2ONEHOT_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  // Buffer occupancy states.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // Each buffer entry holds the result that was decoded when the code was
  // written. The read side therefore does no arithmetic.
  typedef struct packed {
    logic             err;
    logic [OUT_W-1:0] onehot;
  } entry_t;

  logic [1:0] state_q, state_d;
  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  entry_t     new_entry;
  logic       in_ready_q;
  logic       accept;
  logic       emit;

  // ---------------------------------------------------------------------------
  // Decode at write time
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in an always_comb gets a default value first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin : decode
    new_entry = '0;
    if (int'(in) < OUT_W) begin
      new_entry.onehot = OUT_W'(1) << in;
    end else begin
      new_entry.err = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  // in_ready comes from a flop. The input side therefore has no combinational
  // path from out_ready. The skid entry absorbs the cycle of latency.
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign emit      = out_valid && out_ready;

  // The head is gated with out_valid. A stale head left behind after a pop
  // therefore never shows on the port, and out stays zero while idle.
  assign out     = out_valid ? head_q.onehot : '0;
  assign out_err = out_valid && head_q.err;

  // ---------------------------------------------------------------------------
  // Skid buffer next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin : buffer_next
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          head_d  = new_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        unique case ({accept, emit})
          2'b10: begin
            tail_d  = new_entry;
            state_d = ST_TWO;
          end
          2'b01: begin
            state_d = ST_EMPTY;
          end
          2'b11: begin
            // The old head leaves in this cycle, so the new entry takes its place.
            head_d = new_entry;
          end
          default: begin
          end
        endcase
      end
      ST_TWO: begin
        // in_ready was low in this state, so only a pop can occur.
        if (emit) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and data registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments. All
  // flops then sample the values from before the edge, and the result does not
  // depend on the order in which always blocks run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  // NOTE: the two data entries are reset even though out_valid already masks
  // them. With only two entries this is cheap, and the port is then never
  // driven from an unknown value after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Error reporting
  // ---------------------------------------------------------------------------
  logic err_event;
  assign err_event = accept && new_entry.err;

  // If a new error and a clear arrive together, the new error wins. An error
  // that arrives together with the clear is therefore still reported.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_sticky <= 1'b0;
    end else if (err_event) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end

`ifdef ENC_BIN2ONEHOT_ERRCNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (err_event) begin
      if (err_clr) begin
        // The clear drops the old count, and the error in this cycle counts as 1.
        err_cnt <= CNT_W'(1);
      end else if (err_cnt != CNT_MAX) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end else if (err_clr) begin
      err_cnt <= '0;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Interface invariants
  // ---------------------------------------------------------------------------
  // A valid entry is either a single lane, or all-zero with the error flag set.
  a_out_shape: assert property (@(posedge clk) disable iff (!rst)
    out_valid |-> (($onehot(out) && !out_err) || ((out == '0) && out_err)));

  // A stalled entry must not change until the consumer takes it.
  a_out_hold: assert property (@(posedge clk) disable iff (!rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out) && $stable(out_err)));

endmodule

// File: tb/tb_enc_bin2onehot_pipe.sv
// -----------------------------------------------------------------------------
// tb_enc_bin2onehot_pipe
//
// Drives two instances in lockstep from the same stimulus:
//   u_full : IN_W=4, OUT_W=16 (every code maps to a lane)
//   u_part : IN_W=4, OUT_W=12 (codes 12..15 are out of range)
// The reference model is a FIFO queue of expected {err, onehot} words with a
// capacity of two, plus the sticky flag and the counter, which follow the rules
// directly.
// -----------------------------------------------------------------------------
module tb_enc_bin2onehot_pipe;

  localparam int IN_W   = 4;
  localparam int OUT_W  = 16;
  localparam int PART_W = 12;
  localparam int CNT_W  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus
  logic            in_valid  = 1'b0;
  logic [IN_W-1:0] in_code   = '0;
  logic            out_ready = 1'b0;
  logic            err_clr   = 1'b0;

  // Outputs of u_full
  logic              a_in_ready, a_out_valid, a_out_err, a_err_sticky;
  logic [OUT_W-1:0]  a_out;
  // Outputs of u_part
  logic              b_in_ready, b_out_valid, b_out_err, b_err_sticky;
  logic [PART_W-1:0] b_out;
`ifdef ENC_BIN2ONEHOT_ERRCNT_EN
  logic [7:0]        a_err_cnt;
  logic [CNT_W-1:0]  b_err_cnt;
`endif

  enc_bin2onehot_pipe #(
    .IN_W(IN_W), .OUT_W(OUT_W)
`ifdef ENC_BIN2ONEHOT_ERRCNT_EN
    , .CNT_W(8)
`endif
  ) u_full (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(a_in_ready), .in(in_code),
    .out_valid(a_out_valid), .out_ready(out_ready), .out(a_out), .out_err(a_out_err),
    .err_sticky(a_err_sticky), .err_clr(err_clr)
`ifdef ENC_BIN2ONEHOT_ERRCNT_EN
    , .err_cnt(a_err_cnt)
`endif
  );

  enc_bin2onehot_pipe #(
    .IN_W(IN_W), .OUT_W(PART_W)
`ifdef ENC_BIN2ONEHOT_ERRCNT_EN
    , .CNT_W(CNT_W)
`endif
  ) u_part (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(b_in_ready), .in(in_code),
    .out_valid(b_out_valid), .out_ready(out_ready), .out(b_out), .out_err(b_out_err),
    .err_sticky(b_err_sticky), .err_clr(err_clr)
`ifdef ENC_BIN2ONEHOT_ERRCNT_EN
    , .err_cnt(b_err_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [OUT_W:0]  qa[$];
  logic [PART_W:0] qb[$];
  bit              sticky_a = 0, sticky_b = 0;
  int              cnt_b = 0;
  bit              rdy_armed = 0;

  // Expected entry {err, onehot}: bit 'code' is set if the code has a lane,
  // otherwise only the error bit is set.
  function automatic logic [OUT_W:0] ref_a(input int code);
    logic [OUT_W:0] e = '0;
    if (code < OUT_W) e[code] = 1'b1;
    else e[OUT_W] = 1'b1;
    return e;
  endfunction

  function automatic logic [PART_W:0] ref_b(input int code);
    logic [PART_W:0] e = '0;
    if (code < PART_W) e[code] = 1'b1;
    else e[PART_W] = 1'b1;
    return e;
  endfunction

  // Apply one cycle of stimulus at the negative edge, then advance the model
  // past the following rising edge. The task returns 1 time unit after that edge.
  task automatic step(input logic iv, input int code, input logic ordy, input logic clr);
    bit acc_a, acc_b, emit_a, emit_b;
    logic [OUT_W:0]  ea;
    logic [PART_W:0] eb;
    @(negedge clk);
    in_valid  = iv;
    in_code   = IN_W'(code);
    out_ready = ordy;
    err_clr   = clr;
    acc_a  = iv && rdy_armed && (qa.size() < 2);
    acc_b  = iv && rdy_armed && (qb.size() < 2);
    emit_a = (qa.size() > 0) && ordy;
    emit_b = (qb.size() > 0) && ordy;
    ea = ref_a(code);
    eb = ref_b(code);
    @(posedge clk);
    #1;
    if (rst) begin
      if (emit_a) void'(qa.pop_front());
      if (emit_b) void'(qb.pop_front());
      if (acc_a) qa.push_back(ea);
      if (acc_b) qb.push_back(eb);
      if (acc_a && ea[OUT_W]) sticky_a = 1;
      else if (clr) sticky_a = 0;
      if (acc_b && eb[PART_W]) begin
        if (clr) cnt_b = 1;
        else if (cnt_b < (1 << CNT_W) - 1) cnt_b++;
        sticky_b = 1;
      end else if (clr) begin
        cnt_b = 0;
        sticky_b = 0;
      end
      rdy_armed = 1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    checks++; if (a_out !== '0) begin errors++; $display("FAIL reset_out: got %h want 0", a_out); end
    checks++; if (a_err_sticky !== 1'b0 || b_err_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b/%b want 0/0", a_err_sticky, b_err_sticky); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_held: got %b want 0", a_in_ready); end
`ifdef ENC_BIN2ONEHOT_ERRCNT_EN
    checks++; if (b_err_cnt !== '0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", b_err_cnt); end
`endif
    @(negedge clk);
    rst = 1'b1;
    rdy_armed = 0;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready_early: got %b want 0", a_in_ready); end
    @(posedge clk);
    #1;
    rdy_armed = 1;
    checks++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b/%b want 1/1", a_in_ready, b_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b want 0", a_out_valid); end
  endtask

  task automatic test_streaming();
    logic [OUT_W-1:0] want [3];
    int codes [3];
    codes[0] = 0;  codes[1] = 5;  codes[2] = 15;
    want[0] = 16'h0001; want[1] = 16'h0020; want[2] = 16'h8000;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, codes[i], 1'b1, 1'b0);
      checks++;
      if (a_out_valid !== 1'b1 || a_out !== want[i] || a_out_err !== 1'b0 || a_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: got v=%b out=%h err=%b rdy=%b want v=1 out=%h err=0 rdy=1",
                 i, a_out_valid, a_out, a_out_err, a_in_ready, want[i]);
      end
    end
    step(1'b0, 0, 1'b1, 1'b0);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got v=%b want 0", a_out_valid); end
  endtask

  task automatic test_back_pressure();
    step(1'b1, 3, 1'b0, 1'b0);
    checks++; if (a_out !== 16'h0008 || a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_first: got out=%h rdy=%b want 0008/1", a_out, a_in_ready); end
    step(1'b1, 9, 1'b0, 1'b0);
    checks++; if (a_out !== 16'h0008 || a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got out=%h rdy=%b want 0008/0", a_out, a_in_ready); end
    // Offered while full. The code is not taken and must not show up later.
    step(1'b1, 7, 1'b0, 1'b0);
    checks++; if (a_out !== 16'h0008 || a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: got out=%h v=%b want 0008/1", a_out, a_out_valid); end
    step(1'b0, 0, 1'b1, 1'b0);
    checks++; if (a_out !== 16'h0200 || a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_second: got out=%h rdy=%b want 0200/1", a_out, a_in_ready); end
    step(1'b0, 0, 1'b1, 1'b0);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got v=%b want 0", a_out_valid); end
  endtask

  task automatic test_out_of_range();
    step(1'b0, 0, 1'b1, 1'b1);
    checks++; if (b_err_sticky !== 1'b0) begin errors++; $display("FAIL oor_preclear: got %b want 0", b_err_sticky); end
    step(1'b1, 13, 1'b1, 1'b0);
    checks++; if (b_out_valid !== 1'b1 || b_out !== '0 || b_out_err !== 1'b1 || b_err_sticky !== 1'b1) begin
      errors++; $display("FAIL oor_code13: got v=%b out=%h err=%b sticky=%b want 1/000/1/1", b_out_valid, b_out, b_out_err, b_err_sticky);
    end
    checks++; if (a_out !== 16'h2000 || a_err_sticky !== 1'b0) begin errors++; $display("FAIL full_code13: got out=%h sticky=%b want 2000/0", a_out, a_err_sticky); end
`ifdef ENC_BIN2ONEHOT_ERRCNT_EN
    checks++; if (b_err_cnt !== 2'd1) begin errors++; $display("FAIL oor_cnt1: got %0d want 1", b_err_cnt); end
`endif
    step(1'b0, 0, 1'b1, 1'b1);
    checks++; if (b_err_sticky !== 1'b0 || b_out_valid !== 1'b0) begin errors++; $display("FAIL oor_clear: got sticky=%b v=%b want 0/0", b_err_sticky, b_out_valid); end
    step(1'b1, 11, 1'b1, 1'b0);
    checks++; if (b_out !== 12'h800 || b_out_err !== 1'b0 || b_err_sticky !== 1'b0) begin
      errors++; $display("FAIL oor_top_lane: got out=%h err=%b sticky=%b want 800/0/0", b_out, b_out_err, b_err_sticky);
    end
    step(1'b1, 14, 1'b1, 1'b1);
    checks++; if (b_err_sticky !== 1'b1 || b_out_err !== 1'b1) begin errors++; $display("FAIL oor_set_wins: got sticky=%b err=%b want 1/1", b_err_sticky, b_out_err); end
`ifdef ENC_BIN2ONEHOT_ERRCNT_EN
    checks++; if (b_err_cnt !== 2'd1) begin errors++; $display("FAIL oor_cnt_clr_inc: got %0d want 1", b_err_cnt); end
`endif
    step(1'b0, 0, 1'b1, 1'b1);
  endtask

`ifdef ENC_BIN2ONEHOT_ERRCNT_EN
  task automatic test_err_cnt();
    for (int i = 0; i < 5; i++) step(1'b1, 12 + (i % 4), 1'b1, 1'b0);
    checks++; if (b_err_cnt !== 2'd3) begin errors++; $display("FAIL cnt_saturate: got %0d want 3", b_err_cnt); end
    checks++; if (a_err_cnt !== 8'd0) begin errors++; $display("FAIL cnt_full_zero: got %0d want 0", a_err_cnt); end
    step(1'b0, 0, 1'b1, 1'b1);
    checks++; if (b_err_cnt !== 2'd0) begin errors++; $display("FAIL cnt_clear: got %0d want 0", b_err_cnt); end
    step(1'b1, 13, 1'b1, 1'b1);
    checks++; if (b_err_cnt !== 2'd1) begin errors++; $display("FAIL cnt_clr_and_err: got %0d want 1", b_err_cnt); end
    step(1'b0, 0, 1'b1, 1'b1);
  endtask
`endif

  task automatic test_mid_reset();
    step(1'b1, 2, 1'b0, 1'b0);
    step(1'b1, 4, 1'b0, 1'b0);
    checks++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin errors++; $display("FAIL mid_preload: got v=%b rdy=%b want 1/0", a_out_valid, a_in_ready); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_out !== '0 || b_out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_flush: got v=%b out=%h bv=%b want 0/0000/0", a_out_valid, a_out, b_out_valid);
    end
    qa.delete();
    qb.delete();
    sticky_a = 0; sticky_b = 0; cnt_b = 0;
    rdy_armed = 0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL mid_no_ghost: got v=%b rdy=%b want 0/1", a_out_valid, a_in_ready); end
    step(1'b1, 6, 1'b1, 1'b0);
    checks++; if (a_out_valid !== 1'b1 || a_out !== 16'h0040) begin errors++; $display("FAIL mid_new_input: got v=%b out=%h want 1/0040", a_out_valid, a_out); end
    step(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [OUT_W:0]  exp_a;
    logic [PART_W:0] exp_b;
    int bad = 0;
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
      exp_a = (qa.size() > 0) ? qa[0] : '0;
      exp_b = (qb.size() > 0) ? qb[0] : '0;
      checks++;
      if (a_out_valid !== (qa.size() > 0) || a_in_ready !== (qa.size() < 2) ||
          {a_out_err, a_out} !== exp_a || a_err_sticky !== sticky_a) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_full@%0d: got v=%b rdy=%b word=%h st=%b want v=%b rdy=%b word=%h st=%b",
          n, a_out_valid, a_in_ready, {a_out_err, a_out}, a_err_sticky,
          qa.size() > 0, qa.size() < 2, exp_a, sticky_a);
      end
      checks++;
      if (b_out_valid !== (qb.size() > 0) || b_in_ready !== (qb.size() < 2) ||
          {b_out_err, b_out} !== exp_b || b_err_sticky !== sticky_b) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_part@%0d: got v=%b rdy=%b word=%h st=%b want v=%b rdy=%b word=%h st=%b",
          n, b_out_valid, b_in_ready, {b_out_err, b_out}, b_err_sticky,
          qb.size() > 0, qb.size() < 2, exp_b, sticky_b);
      end
`ifdef ENC_BIN2ONEHOT_ERRCNT_EN
      checks++;
      if (int'(b_err_cnt) != cnt_b) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_cnt@%0d: got %0d want %0d", n, b_err_cnt, cnt_b);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_out_of_range();
`ifdef ENC_BIN2ONEHOT_ERRCNT_EN
    test_err_cnt();
`endif
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
